mul_fp32_ctrl: RTL



---
 rtl/mul_fp32_ctrl_pkg.sv | 29 ++
 rtl/mul_fp32_ctrl_if.sv | 30 +++
 rtl/mul_fp32_ctrl_fifo_sync.sv | 67 ++++++
 rtl/mul_fp32_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mul_fp32_ctrl_pkg.sv
// Shared definitions for the mul_fp32 issue/collect controller:
// rounding-mode encodings, multiplier latency and the response payload type.
package mul_fp32_ctrl_pkg;

    // Fixed pipeline depth of mul_fp32: inputs at d0, outputs visible at d4.
    localparam int MUL_FP32_LAT = 4;

    // Width of the rounding-mode field.
    localparam int RM_W = 3;

    // Rounding-mode encodings understood by mul_fp32.
    typedef enum logic [RM_W-1:0] {
        RM_RTE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rm_e;

    // Per-op result as captured from mul_fp32 and held in the response FIFO.
    typedef struct packed {
        logic [31:0] result;
        logic        nv;
        logic        of;
    } mul_rsp_t;

    localparam int RSP_W = $bits(mul_rsp_t);

endpackage

// File: rtl/mul_fp32_ctrl_if.sv
// Request/response handshake bundle between a client and mul_fp32_ctrl.
// The client side uses the master modport, the controller the slave modport.
interface mul_fp32_ctrl_if #(parameter int TAG_W = 4);
    import mul_fp32_ctrl_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [RM_W-1:0]  req_rm;
    logic [31:0]      req_src1;
    logic [31:0]      req_src2;
    logic [TAG_W-1:0] req_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_nv;
    logic             rsp_of;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_rm, req_src1, req_src2, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_nv, rsp_of, rsp_tag
    );

    modport slave (
        input  req_valid, req_rm, req_src1, req_src2, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_nv, rsp_of, rsp_tag
    );

endinterface

// File: rtl/mul_fp32_ctrl_fifo_sync.sv
// fifo_sync: synchronous show-ahead FIFO with registered storage.
// The head entry is always visible on pop_data; push and pop in the same
// cycle are both honoured, including when the FIFO is full.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Read/write pointers and occupancy count.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mul_fp32_ctrl.sv
// mul_fp32_ctrl: issue/collect controller wrapped around mul_fp32.
// Requests are forwarded to the multiplier in the accept cycle, tracked
// through its fixed latency and their results queued in a response FIFO.
// A credit counter bounds in-flight plus buffered ops to DEPTH, so the FIFO
// can never overflow even though mul_fp32 cannot stall.
// Optional build macro MUL_FP32_CTRL_FLAGS_EN adds sticky nv/of flags
// (ports flags_clr, flags_nv, flags_of).
module mul_fp32_ctrl
    import mul_fp32_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = 4,
    parameter int LAT   = MUL_FP32_LAT
) (
    input  logic            clock,
    input  logic            reset,
    mul_fp32_ctrl_if.slave  bus,
    output logic            mul_en,
    output logic [RM_W-1:0] mul_rm,
    output logic [31:0]     mul_src1,
    output logic [31:0]     mul_src2,
    input  logic [31:0]     mul_result,
    input  logic            mul_nv,
    input  logic            mul_of,
    output logic            busy
`ifdef MUL_FP32_CTRL_FLAGS_EN
    ,
    input  logic            flags_clr,
    output logic            flags_nv,
    output logic            flags_of
`endif
);

    localparam int CNT_W   = $clog2(DEPTH+1);
    localparam int ENTRY_W = RSP_W + TAG_W;

    logic [CNT_W-1:0]   cnt;
    logic               fire;
    logic               pop;
    logic [LAT-1:0]     vld;
    logic [TAG_W-1:0]   tag_pipe [LAT];
    logic               push;
    mul_rsp_t           push_rsp;
    mul_rsp_t           head_rsp;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    // Credits come only from registers (and reset), never from rsp_ready.
    assign bus.req_ready = !reset && (cnt < CNT_W'(DEPTH));
    assign fire          = bus.req_valid && bus.req_ready;
    assign pop           = bus.rsp_valid && bus.rsp_ready;

    // The op enters mul_fp32 in the accept cycle.
    assign mul_en   = fire;
    assign mul_rm   = bus.req_rm;
    assign mul_src1 = bus.req_src1;
    assign mul_src2 = bus.req_src2;

    assign busy = (cnt != '0);

    // Credit counter: ops accepted and not yet popped.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            case ({fire, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Valid bits shadowing the multiplier pipeline; cleared on reset so late results are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld <= '0;
        end else begin
            vld[0] <= fire;
            for (int k = 1; k < LAT; k++) begin
                vld[k] <= vld[k-1];
            end
        end
    end

    // Tags travel alongside the valid bits and need no reset.
    always_ff @(posedge clock) begin
        tag_pipe[0] <= bus.req_tag;
        for (int k = 1; k < LAT; k++) begin
            tag_pipe[k] <= tag_pipe[k-1];
        end
    end

    // When the last tracking stage is valid, the multiplier outputs belong to its tag.
    assign push      = vld[LAT-1];
    assign push_rsp  = '{result: mul_result, nv: mul_nv, of: mul_of};
    assign push_data = {push_rsp, tag_pipe[LAT-1]};

    fifo_sync #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign {head_rsp, bus.rsp_tag} = head;
    assign bus.rsp_valid  = !fifo_empty;
    assign bus.rsp_result = head_rsp.result;
    assign bus.rsp_nv     = head_rsp.nv;
    assign bus.rsp_of     = head_rsp.of;

    // Credit invariant: the FIFO never receives a push while full and never holds more than cnt.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(push && fifo_full));
            assert (fifo_count <= cnt);
        end
    end

`ifdef MUL_FP32_CTRL_FLAGS_EN
    // Sticky flags; a pop in the clear cycle still sets them.
    always_ff @(posedge clock) begin
        if (reset) begin
            flags_nv <= 1'b0;
            flags_of <= 1'b0;
        end else begin
            flags_nv <= (flags_clr ? 1'b0 : flags_nv) | (pop & bus.rsp_nv);
            flags_of <= (flags_clr ? 1'b0 : flags_of) | (pop & bus.rsp_of);
        end
    end
`endif

endmodule
